// File: rtl/shared_data_mem.sv
// Per-core private data banks plus one round-robin arbitrated shared bank.
// Latency: writes commit at the accepting edge; load data and valid appear one cycle later.
// Backpressure: only shared-bank losers see dataStall (combinational) and must hold the request.
module shared_data_mem #(
  parameter int NCORES = 2,
  parameter int LMEM   = 8,
  parameter int TAM    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORES*TAM-1:0]  dataIN,
  input  logic [NCORES*TAM-1:0]  dataADDR,
  input  logic [NCORES-1:0]      dataWrite,
  input  logic [NCORES-1:0]      dataLoad,
  output logic [NCORES*TAM-1:0]  dataOUT,
  output logic [NCORES-1:0]      dataValid,
  output logic [NCORES-1:0]      dataStall
);

  localparam int DEPTH = 1 << LMEM;
  localparam int PW    = (NCORES > 1) ? $clog2(NCORES) : 1;

  // Storage: never reset, contents are undefined until written.
  logic [TAM-1:0] priv_mem_q   [NCORES][DEPTH];
  logic [TAM-1:0] shared_mem_q [DEPTH];

  // Per-core decoded request fields.
  logic [TAM-1:0]    core_wdat   [NCORES];
  logic [LMEM-1:0]   core_idx    [NCORES];
  logic [NCORES-1:0] core_shared;
  logic [NCORES-1:0] core_req;
  logic [NCORES-1:0] core_ld_only;
  logic [NCORES-1:0] unused_addr_bits;

  // Arbitration and acceptance.
  logic [NCORES-1:0] sh_req;
  logic [NCORES-1:0] priv_acc;
  logic [NCORES-1:0] gnt_oh;
  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     ptr_q, ptr_d;

  // Shared bank single port, driven by the granted core.
  logic              sh_we;
  logic [LMEM-1:0]   sh_idx;
  logic [TAM-1:0]    sh_wdat;
  logic [TAM-1:0]    sh_rdat;

  // Output registers.
  logic [NCORES*TAM-1:0] dout_q, dout_d;
  logic [NCORES-1:0]     vld_q, vld_d;

  // Slice the packed buses per core; bank select is the bit just above the index.
  always_comb begin
    core_shared      = '0;
    unused_addr_bits = '0;
    for (int i = 0; i < NCORES; i++) begin
      core_wdat[i]        = dataIN[i*TAM +: TAM];
      core_idx[i]         = dataADDR[i*TAM +: LMEM];
      core_shared[i]      = dataADDR[i*TAM + LMEM];
      unused_addr_bits[i] = ^dataADDR[i*TAM +: TAM];
    end
  end

  // A write with a simultaneous load is a plain write: no load result is returned.
  assign core_req     = dataWrite | dataLoad;
  assign core_ld_only = dataLoad & ~dataWrite;

  // Reset masks every request so nothing is accepted and nothing stalls.
  assign sh_req   = rst ? '0 : (core_req & core_shared);
  assign priv_acc = rst ? '0 : (core_req & ~core_shared);

  // Round-robin: first shared requester at or after the pointer, wrapping.
  always_comb begin
    int c;
    c       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NCORES; k++) begin
      c = (int'(ptr_q) + k) % NCORES;
      if (!gnt_vld && sh_req[c]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = PW'(c);
        gnt_oh[c] = 1'b1;
      end
    end
  end

  assign dataStall = sh_req & ~gnt_oh;

  // Pointer moves past the winner; idle cycles leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == PW'(NCORES - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Shared port mux; the read returns pre-write contents by construction.
  always_comb begin
    sh_we   = gnt_vld & dataWrite[gnt_idx];
    sh_idx  = core_idx[gnt_idx];
    sh_wdat = core_wdat[gnt_idx];
    sh_rdat = shared_mem_q[sh_idx];
  end

  // Load results: capture bank data for accepted load-only requests, else hold.
  always_comb begin
    dout_d = dout_q;
    vld_d  = '0;
    for (int i = 0; i < NCORES; i++) begin
      vld_d[i] = (priv_acc[i] | gnt_oh[i]) & core_ld_only[i];
      if (vld_d[i]) begin
        dout_d[i*TAM +: TAM] = core_shared[i] ? sh_rdat : priv_mem_q[i][core_idx[i]];
      end
    end
  end

  // Output and arbiter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= '0;
      ptr_q  <= '0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  // Bank writes; acceptance terms are already masked by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCORES; i++) begin
      if (priv_acc[i] && dataWrite[i]) begin
        priv_mem_q[i][core_idx[i]] <= core_wdat[i];
      end
    end
    if (sh_we) begin
      shared_mem_q[sh_idx] <= sh_wdat;
    end
  end

  assign dataOUT   = dout_q;
  assign dataValid = vld_q;

endmodule
